fifo_drain_checker: RTL and testbench
=====================================

Name: fifo_drain_checker

Overview:
- Read-side companion to the FIFO under test; the write side is fed by an LFSR data generator.
- Drains the FIFO through its RE / DOUT / flag interface.
- Regenerates the expected LFSR byte sequence locally, compares every accepted read word, and keeps read and error counts.
- Lets a bench or on-chip self-test run FIFO data-integrity checks without a behavioural reference model.

Parameters:
- SEED, 8'h01: LFSR value after reset; must be nonzero and equal to the generator's seed.
- MODE, 0: 0 = continuous (read whenever not empty); 1 = burst (start at PFF/FF, drain until EF).
- CNT_W, 16: width of RD_CNT and ERR_CNT.

Ports:
- clk  in  1  system clock; all state changes on the posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  permits new reads when 1.
- DOUT  in  8  FIFO read data; valid the cycle after an accepted read.
- EF  in  1  FIFO empty flag.
- PEF  in  1  FIFO partially-empty flag (status only; not used for control).
- FF  in  1  FIFO full flag.
- PFF  in  1  FIFO partially-full flag.
- RE  out  1  registered read enable to the FIFO.
- EXPECTED  out  8  current expected byte (LFSR state).
- ERR  out  1  one-cycle pulse on a miscompare.
- STICKY_ERR  out  1  set on the first miscompare; cleared only by reset.
- ERR_CNT  out  CNT_W  miscompare count, saturating.
- RD_CNT  out  CNT_W  accepted-read count, saturating.
- BUSY  out  1  1 while in the DRAIN state.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - RE=0, ERR=0, STICKY_ERR=0, ERR_CNT=0, RD_CNT=0, BUSY=0, EXPECTED=SEED.
  - State=IDLE; the pending flag is cleared.
  - Takes effect immediately, including mid-drain; an in-flight compare is discarded.
- Read acceptance:
  - A read is accepted at a posedge where RE=1 and EF=0.
  - RE=1 with EF=1 is a no-op: no count, no compare, no LFSR step.
- Pipeline:
  - On an accepted read, set pending=1 for the next cycle.
  - On the following posedge with pending=1, compare DOUT against EXPECTED, then advance the LFSR.
  - Read-to-compare latency is one cycle; back-to-back reads compare every cycle.
- LFSR:
  - 8-bit Fibonacci, shift left: next = {q[6:0], q[7]^q[5]^q[4]^q[3]} (x^8+x^6+x^5+x^4+1).
  - Period 255; never reaches 0.
- Miscompare:
  - ERR=1 for exactly that cycle; ERR_CNT increments; STICKY_ERR set.
  - EXPECTED still advances, so one bad word yields exactly one error.
- RD_CNT increments on every accepted read.
- Both counters saturate at all-ones and never wrap.
- State machine (registered; RE = (state==DRAIN) && !EF, evaluated on flags sampled at the same edge):
  - IDLE:
    - MODE0: go to DRAIN when ENABLE=1.
    - MODE1: go to DRAIN when ENABLE=1 and (PFF|FF)=1.
  - DRAIN:
    - ENABLE=0 -> IDLE.
    - MODE1 and EF=1 -> IDLE.
    - MODE0 stays in DRAIN while EF=1, with RE forced low.
- Boundary conditions:
  - EF rising while RE=1: that edge's read is not accepted; RE drops on the next cycle.
  - ENABLE dropped mid-drain: no new reads after the next edge; the pending compare still completes.
  - FF=1 while draining: no effect beyond the burst trigger.
- BUSY = (state==DRAIN).

Test Plan:
1. Reset and idle:
   - Assert RESET_N=0 mid-operation with RE=1 -> RE=0, counters 0, EXPECTED=8'h01 within the same time step, before any clock edge.
   - Release with ENABLE=0 -> RE stays 0.
2. Continuous drain:
   - MODE=0, FIFO preloaded with 10 LFSR bytes from seed 8'h01, then ENABLE=1.
   - Expect 10 accepted reads, RD_CNT=10, ERR_CNT=0, STICKY_ERR=0.
   - RE low within 1 cycle of EF=1.
   - EXPECTED sequence begins 01,02,04,08,11,...
3. Single corruption:
   - Flip bit 0 of the 4th word (expected 8'h08 presented as 8'h09).
   - Expect one ERR pulse aligned with that compare, ERR_CNT=1, STICKY_ERR=1.
   - The remaining 6 words compare clean; final RD_CNT=10.
4. Burst mode:
   - MODE=1, write words one at a time.
   - RE must remain 0 until PFF rises; then RE=1 on the next cycle.
   - Drains until EF=1, returns to IDLE (BUSY=0); RD_CNT equals the number written.
5. Empty underflow:
   - MODE=0, ENABLE=1, FIFO empty for 20 cycles -> RE=0 throughout, RD_CNT=0, EXPECTED unchanged at 8'h01.
6. Saturation:
   - CNT_W=4, stream 20 words with every word corrupted.
   - Expect RD_CNT=15 and ERR_CNT=15, both holding (no wrap).

Source files
------------

// File: rtl/fifo_drain_checker.sv
// fifo_drain_checker: read-side companion to an LFSR-fed FIFO under test.
// Drains the FIFO, regenerates the expected byte stream locally and compares
// every accepted read word, keeping saturating read and error counts.
module fifo_drain_checker #(
  parameter logic [7:0]  SEED  = 8'h01,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic [7:0]       DOUT,
  input  logic             EF,
  input  logic             PEF,
  input  logic             FF,
  input  logic             PFF,
  output logic             RE,
  output logic [7:0]       EXPECTED,
  output logic             ERR,
  output logic             STICKY_ERR,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] RD_CNT,
  output logic             BUSY
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_re;
  logic             r_busy;
  logic             r_pending;
  logic             r_err;
  logic             r_sticky;
  logic [7:0]       r_lfsr;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_re_nxt;
  logic             w_burst;
  logic             w_accept;
  logic             w_miscmp;
  logic [7:0]       w_lfsr_nxt;
  logic             w_unused;

  // PEF is a status-only flag; it is deliberately not part of the control path
  assign w_unused = PEF;

  assign w_burst    = (MODE != 0);
  assign w_accept   = r_re && !EF;
  assign w_miscmp   = r_pending && (DOUT != r_lfsr);
  assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // Next-state and next read-enable from the flags sampled at this edge
  always_comb begin
    w_state_nxt = r_state;
    w_re_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ENABLE && (!w_burst || PFF || FF)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!ENABLE || (w_burst && EF)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_re_nxt = (w_state_nxt == S_DRAIN) && !EF;
  end

  // State register with registered RE and BUSY
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_re    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_re    <= w_re_nxt;
      r_busy  <= (w_state_nxt == S_DRAIN);
    end
  end

  // Compare pipeline: accepted read arms a compare on the following edge
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pending <= 1'b0;
      r_err     <= 1'b0;
      r_sticky  <= 1'b0;
      r_lfsr    <= SEED;
    end else begin
      r_pending <= w_accept;
      r_err     <= w_miscmp;
      if (w_miscmp) begin
        r_sticky <= 1'b1;
      end
      if (r_pending) begin
        r_lfsr <= w_lfsr_nxt;
      end
    end
  end

  // Saturating read and miscompare counters
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rd_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept && (r_rd_cnt != CNT_MAX)) begin
        r_rd_cnt <= r_rd_cnt + CNT_ONE;
      end
      if (w_miscmp && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + CNT_ONE;
      end
    end
  end

  assign RE         = r_re;
  assign BUSY       = r_busy;
  assign EXPECTED   = r_lfsr;
  assign ERR        = r_err;
  assign STICKY_ERR = r_sticky;
  assign ERR_CNT    = r_err_cnt;
  assign RD_CNT     = r_rd_cnt;

endmodule

// File: tb/tb_fifo_drain_checker.sv
// Bench for fifo_drain_checker: a queue-based FIFO model feeds three instances
// (continuous, burst, 4-bit counters); only the selected one is enabled.
module tb_fifo_drain_checker;

  typedef struct packed {
    logic [7:0] d;
    logic       bad;
  } word_t;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned PFF_LVL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RESET_N;
  logic       ENABLE;
  logic [7:0] DOUT;
  logic       EF, PEF, FF, PFF;
  int         sel;

  logic en_c, en_b, en_s;
  assign en_c = ENABLE && (sel == 0);
  assign en_b = ENABLE && (sel == 1);
  assign en_s = ENABLE && (sel == 2);

  logic        re_c, re_b, re_s;
  logic [7:0]  exp_c, exp_b, exp_s;
  logic        err_c, err_b, err_s;
  logic        st_c, st_b, st_s;
  logic        busy_c, busy_b, busy_s;
  logic [15:0] rdc_c, rdc_b, errc_c, errc_b;
  logic [3:0]  rdc_s, errc_s;

  fifo_drain_checker #(.SEED(8'h01), .MODE(0), .CNT_W(16)) u_dut_c (
    .clk(clk), .RESET_N(RESET_N), .ENABLE(en_c), .DOUT(DOUT), .EF(EF), .PEF(PEF),
    .FF(FF), .PFF(PFF), .RE(re_c), .EXPECTED(exp_c), .ERR(err_c),
    .STICKY_ERR(st_c), .ERR_CNT(errc_c), .RD_CNT(rdc_c), .BUSY(busy_c));

  fifo_drain_checker #(.SEED(8'h01), .MODE(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .RESET_N(RESET_N), .ENABLE(en_b), .DOUT(DOUT), .EF(EF), .PEF(PEF),
    .FF(FF), .PFF(PFF), .RE(re_b), .EXPECTED(exp_b), .ERR(err_b),
    .STICKY_ERR(st_b), .ERR_CNT(errc_b), .RD_CNT(rdc_b), .BUSY(busy_b));

  fifo_drain_checker #(.SEED(8'h01), .MODE(0), .CNT_W(4)) u_dut_s (
    .clk(clk), .RESET_N(RESET_N), .ENABLE(en_s), .DOUT(DOUT), .EF(EF), .PEF(PEF),
    .FF(FF), .PFF(PFF), .RE(re_s), .EXPECTED(exp_s), .ERR(err_s),
    .STICKY_ERR(st_s), .ERR_CNT(errc_s), .RD_CNT(rdc_s), .BUSY(busy_s));

  // Outputs of the instance currently under test
  logic        w_re, w_err, w_sticky, w_busy;
  logic [7:0]  w_exp;
  logic [15:0] w_rdc, w_errc;
  always_comb begin
    w_re = re_c; w_err = err_c; w_sticky = st_c; w_busy = busy_c;
    w_exp = exp_c; w_rdc = rdc_c; w_errc = errc_c;
    if (sel == 1) begin
      w_re = re_b; w_err = err_b; w_sticky = st_b; w_busy = busy_b;
      w_exp = exp_b; w_rdc = rdc_b; w_errc = errc_b;
    end else if (sel == 2) begin
      w_re = re_s; w_err = err_s; w_sticky = st_s; w_busy = busy_s;
      w_exp = exp_s; w_rdc = {12'd0, rdc_s}; w_errc = {12'd0, errc_s};
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // FIFO model and scoreboard state
  word_t      fifo_q[$];
  logic       sb_q[$];
  logic [7:0] g_lfsr  = 8'h01;
  logic [7:0] m_lfsr  = 8'h01;
  int         m_rd    = 0;
  int         m_err   = 0;
  int         cnt_max = 65535;
  int         n_pulse = 0;
  logic       acc_last = 1'b0;
  logic       due      = 1'b0;

  function automatic void update_flags();
    EF  = (fifo_q.size() == 0);
    PEF = (fifo_q.size() <= 2);
    FF  = (fifo_q.size() >= DEPTH);
    PFF = (fifo_q.size() >= PFF_LVL);
  endfunction

  task automatic push_word(input logic bad);
    word_t w;
    w.d    = g_lfsr ^ {7'd0, bad};
    w.bad  = bad;
    g_lfsr = lfsr_step(g_lfsr);
    fifo_q.push_back(w);
    update_flags();
  endtask

  // FIFO read port plus per-cycle checks of ERR, EXPECTED and RE
  initial begin : model
    logic  acc;
    logic  ef_edge;
    logic  en_edge;
    logic  e;
    word_t w;
    ef_edge = 1'b1;
    en_edge = 1'b0;
    forever begin
      @(negedge clk);
      if (w_err) n_pulse++;
      if (due) begin
        if (sb_q.size() == 0) begin
          chk("sb_underrun", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("err_pulse", 32'(w_err), 32'(e));
          if (e && (m_err < cnt_max)) m_err++;
        end
        m_lfsr = lfsr_step(m_lfsr);
      end else begin
        chk("err_idle", 32'(w_err), 32'd0);
      end
      chk("expected", 32'(w_exp), 32'(m_lfsr));
      if (ef_edge || !en_edge) chk("re_low", 32'(w_re), 32'd0);
      #4;
      acc      = w_re && !EF && RESET_N;
      due      = acc_last;
      acc_last = acc;
      ef_edge  = EF;
      en_edge  = ENABLE;
      @(posedge clk);
      #1;
      if (acc) begin
        if (fifo_q.size() == 0) begin
          chk("model_underrun", 32'd1, 32'd0);
        end else begin
          w    = fifo_q.pop_front();
          DOUT = w.d;
          sb_q.push_back(w.bad);
          if (m_rd < cnt_max) m_rd++;
        end
      end
      update_flags();
    end
  end

  task automatic do_reset(input int new_sel);
    @(negedge clk);
    #1;
    RESET_N = 1'b0;
    ENABLE  = 1'b0;
    #1;
    chk("rst_re", 32'(w_re), 32'd0);
    chk("rst_rd_cnt", 32'(w_rdc), 32'd0);
    chk("rst_err_cnt", 32'(w_errc), 32'd0);
    chk("rst_expected", 32'(w_exp), 32'h01);
    chk("rst_sticky", 32'(w_sticky), 32'd0);
    chk("rst_busy", 32'(w_busy), 32'd0);
    sel = new_sel;
    fifo_q.delete();
    sb_q.delete();
    acc_last = 1'b0;
    due      = 1'b0;
    m_lfsr   = 8'h01;
    g_lfsr   = 8'h01;
    m_rd     = 0;
    m_err    = 0;
    n_pulse  = 0;
    cnt_max  = (new_sel == 2) ? 15 : 65535;
    update_flags();
    repeat (2) @(negedge clk);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && !w_re && sb_q.size() == 0 && !acc_last) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [7:0] e10;
    RESET_N = 1'b0;
    ENABLE  = 1'b0;
    sel     = 0;
    DOUT    = 8'h00;
    update_flags();
    repeat (2) @(negedge clk);
    #1;
    RESET_N = 1'b1;

    // 1: reset mid-drain, then release with ENABLE low
    for (int i = 0; i < 10; i++) push_word(1'b0);
    ENABLE = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_reset_re", 32'(w_re), 32'd1);
    do_reset(0);
    repeat (5) @(negedge clk);
    chk("idle_re", 32'(w_re), 32'd0);

    // 2: continuous drain of 10 clean words
    for (int i = 0; i < 10; i++) push_word(1'b0);
    ENABLE = 1'b1;
    wait_drain();
    e10 = 8'h01;
    for (int i = 0; i < 10; i++) e10 = lfsr_step(e10);
    chk("cont_rd_cnt", 32'(w_rdc), 32'd10);
    chk("cont_rd_model", 32'(w_rdc), 32'(m_rd));
    chk("cont_err_cnt", 32'(w_errc), 32'd0);
    chk("cont_sticky", 32'(w_sticky), 32'd0);
    chk("cont_busy", 32'(w_busy), 32'd1);
    chk("cont_expected", 32'(w_exp), 32'(e10));

    // 3: fourth word corrupted (08 presented as 09)
    do_reset(0);
    for (int i = 0; i < 10; i++) push_word(i == 3);
    ENABLE = 1'b1;
    wait_drain();
    chk("corr_rd_cnt", 32'(w_rdc), 32'd10);
    chk("corr_err_cnt", 32'(w_errc), 32'd1);
    chk("corr_sticky", 32'(w_sticky), 32'd1);
    chk("corr_pulses", 32'(n_pulse), 32'd1);

    // 4: burst mode waits for PFF, drains to empty, returns idle
    do_reset(1);
    ENABLE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge clk);
      chk("burst_wait_re", 32'(w_re), 32'd0);
      chk("burst_wait_busy", 32'(w_busy), 32'd0);
      #1;
      push_word(1'b0);
    end
    @(negedge clk);
    chk("burst_start_re", 32'(w_re), 32'd1);
    chk("burst_start_busy", 32'(w_busy), 32'd1);
    wait_drain();
    chk("burst_end_busy", 32'(w_busy), 32'd0);
    chk("burst_rd_cnt", 32'(w_rdc), 32'd4);
    chk("burst_err_cnt", 32'(w_errc), 32'd0);

    // 5: enabled on an empty FIFO
    do_reset(0);
    ENABLE = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("uflow_re", 32'(w_re), 32'd0);
    end
    chk("uflow_rd_cnt", 32'(w_rdc), 32'd0);
    chk("uflow_expected", 32'(w_exp), 32'h01);

    // 6: 4-bit counters saturate on 20 corrupted words
    do_reset(2);
    for (int i = 0; i < 20; i++) push_word(1'b1);
    ENABLE = 1'b1;
    wait_drain();
    chk("sat_rd_cnt", 32'(w_rdc), 32'd15);
    chk("sat_err_cnt", 32'(w_errc), 32'd15);
    chk("sat_sticky", 32'(w_sticky), 32'd1);
    chk("sat_pulses", 32'(n_pulse), 32'd20);
    repeat (5) @(negedge clk);
    chk("sat_rd_hold", 32'(w_rdc), 32'd15);
    chk("sat_err_hold", 32'(w_errc), 32'd15);

    ENABLE = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
